// File: rtl/sign_truncator.sv
// Narrows two's-complement samples from INPUT_WIDTH to OUTPUT_WIDTH, saturating or wrapping.
// Latency: 1 cycle from input accept to out_valid when the output register is free.
// Backpressure: 1-entry skid absorbs a sample accepted while output is held; in_ready drops until it drains.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready/in_data  input stream (in_ready registered)
//   saturate_en                1: clamp out-of-range, 0: keep low OUTPUT_WIDTH bits
//   out_valid/out_ready        output stream
//   out_data/out_overflow      narrowed sample and its per-sample overflow flag
//   overflow_sticky            set by any accepted overflow, cleared by clear/reset
//   overflow_count             accepted overflow samples, saturating
//   clear                      synchronous clear of sticky flag and counter
module sign_truncator #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUT_WIDTH-1:0]  in_data,
    input  logic                    saturate_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic                    out_overflow,
    output logic                    overflow_sticky,
    output logic [COUNT_WIDTH-1:0]  overflow_count,
    input  logic                    clear
);

    localparam logic [OUTPUT_WIDTH-1:0] SAT_POS = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic [OUTPUT_WIDTH-1:0] SAT_NEG = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    localparam logic [COUNT_WIDTH-1:0]  CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0]  CNT_MAX = {COUNT_WIDTH{1'b1}};

    logic                    r_in_rdy;
    logic                    r_out_vld;
    logic [OUTPUT_WIDTH-1:0] r_out_dat;
    logic                    r_out_ovf;
    logic                    r_skid_vld;
    logic [OUTPUT_WIDTH-1:0] r_skid_dat;
    logic                    r_skid_ovf;
    logic                    r_sticky;
    logic [COUNT_WIDTH-1:0]  r_count;

    logic [INPUT_WIDTH-OUTPUT_WIDTH:0] w_top;
    logic                    w_ovf;
    logic [OUTPUT_WIDTH-1:0] w_res;
    logic                    w_acc;
    logic                    w_out_free;
    logic                    w_skid_vld_nxt;
    logic [COUNT_WIDTH-1:0]  w_cnt_base;

    // The value fits iff every bit from the input MSB down to the output
    // sign position is a copy of the sign.
    assign w_top = in_data[INPUT_WIDTH-1:OUTPUT_WIDTH-1];
    assign w_ovf = !((&w_top) || !(|w_top));

    always_comb begin
        w_res = in_data[OUTPUT_WIDTH-1:0];
        if (saturate_en && w_ovf) begin
            w_res = in_data[INPUT_WIDTH-1] ? SAT_NEG : SAT_POS;
        end
    end

    assign w_acc      = in_valid && r_in_rdy;
    assign w_out_free = !r_out_vld || out_ready;

    // Skid fills only when a sample arrives while the output is held, and
    // drains whenever the output register frees up (input is blocked then).
    always_comb begin
        w_skid_vld_nxt = r_skid_vld;
        if (w_out_free) begin
            w_skid_vld_nxt = 1'b0;
        end else if (w_acc) begin
            w_skid_vld_nxt = 1'b1;
        end
    end

    // clear wipes the history first, so an overflow accepted in the same
    // cycle is still counted on top of zero.
    assign w_cnt_base = clear ? '0 : r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_rdy   <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_ovf  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_skid_dat <= '0;
            r_skid_ovf <= 1'b0;
            r_sticky   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_in_rdy   <= !w_skid_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;

            if (w_out_free) begin
                if (r_skid_vld) begin
                    r_out_vld <= 1'b1;
                    r_out_dat <= r_skid_dat;
                    r_out_ovf <= r_skid_ovf;
                end else if (w_acc) begin
                    r_out_vld <= 1'b1;
                    r_out_dat <= w_res;
                    r_out_ovf <= w_ovf;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end else if (w_acc) begin
                r_skid_dat <= w_res;
                r_skid_ovf <= w_ovf;
            end

            if (w_acc && w_ovf) begin
                r_sticky <= 1'b1;
                r_count  <= (w_cnt_base == CNT_MAX) ? CNT_MAX : w_cnt_base + CNT_ONE;
            end else begin
                if (clear) begin
                    r_sticky <= 1'b0;
                end
                r_count <= w_cnt_base;
            end
        end
    end

    assign in_ready        = r_in_rdy;
    assign out_valid       = r_out_vld;
    assign out_data        = r_out_dat;
    assign out_overflow    = r_out_ovf;
    assign overflow_sticky = r_sticky;
    assign overflow_count  = r_count;

endmodule

// File: tb/tb_sign_truncator.sv
module tb_sign_truncator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        saturate_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_overflow;
    logic        overflow_sticky;
    logic [15:0] overflow_count;
    logic        clear;

    // Second instance with a 2-bit counter to exercise counter saturation.
    logic        c2_in_ready;
    logic        c2_out_valid;
    logic [7:0]  c2_out_data;
    logic        c2_out_overflow;
    logic        c2_sticky;
    logic [1:0]  c2_count;

    always #5 clk = ~clk;

    sign_truncator #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .saturate_en(saturate_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_overflow(out_overflow),
        .overflow_sticky(overflow_sticky), .overflow_count(overflow_count), .clear(clear)
    );

    sign_truncator #(.INPUT_WIDTH(16), .OUTPUT_WIDTH(8), .COUNT_WIDTH(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c2_in_ready),
        .in_data(in_data), .saturate_en(saturate_en), .out_valid(c2_out_valid),
        .out_ready(out_ready), .out_data(c2_out_data), .out_overflow(c2_out_overflow),
        .overflow_sticky(c2_sticky), .overflow_count(c2_count), .clear(clear)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: samples accepted but not yet transferred, as {ovf, data}.
    logic [8:0] q[$];
    int         m_cnt;
    int         m_cnt2;
    bit         m_stk;

    typedef struct {
        logic [15:0] din;
        logic        sat;
        logic [7:0]  exp_dat;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Narrowing by value range and arithmetic clamp, independent of bit slicing.
    function automatic logic [8:0] ref_model(input logic [15:0] d, input logic sat);
        int v;
        int r;
        logic ovf;
        v   = int'(signed'(d));
        ovf = (v > 127) || (v < -128);
        if (sat && v > 127)       r = 127;
        else if (sat && v < -128) r = -128;
        else                      r = v;
        r = ((r % 256) + 256) % 256;
        return {ovf, 8'(r)};
    endfunction

    task automatic drive(input logic vld, input logic [15:0] d, input logic sat,
                         input logic ordy, input logic clr);
        in_valid    = vld;
        in_data     = d;
        saturate_en = sat;
        out_ready   = ordy;
        clear       = clr;
    endtask

    // One clock: check the held output against the model, advance, update the model,
    // then check the registered handshake and overflow state.
    task automatic tick();
        logic       acc;
        logic       xfer;
        logic [8:0] r;
        acc  = in_valid && in_ready && rst_n;
        xfer = out_valid && out_ready;
        r    = ref_model(in_data, saturate_en);
        if (rst_n && out_valid) begin
            if (q.size() == 0) chk("out_valid_without_sample", 1, 0);
            else               chk("out_sample", {out_overflow, out_data}, q[0]);
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            m_cnt  = 0;
            m_cnt2 = 0;
            m_stk  = 0;
            chk("reset_state", {out_valid, in_ready, overflow_sticky, out_overflow, out_data, overflow_count}, 0);
            chk("reset_state_c2", {c2_out_valid, c2_in_ready, c2_sticky, c2_count}, 0);
        end else begin
            if (xfer && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(r);
            if (clear) begin
                m_cnt  = 0;
                m_cnt2 = 0;
                m_stk  = 0;
            end
            if (acc && r[8]) begin
                m_stk = 1;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            chk("overflow_count", overflow_count, m_cnt);
            chk("overflow_sticky", overflow_sticky, m_stk);
            chk("overflow_count_c2", c2_count, m_cnt2);
            chk("overflow_sticky_c2", c2_sticky, m_stk);
        end
    endtask

    initial begin
        vecs[0] = '{16'h007F, 1'b1, 8'h7F, 1'b0};
        vecs[1] = '{16'hFF80, 1'b1, 8'h80, 1'b0};
        vecs[2] = '{16'h0080, 1'b1, 8'h7F, 1'b1};
        vecs[3] = '{16'h8000, 1'b1, 8'h80, 1'b1};
        vecs[4] = '{16'h0123, 1'b0, 8'h23, 1'b1};
        vecs[5] = '{16'hFFFE, 1'b0, 8'hFE, 1'b0};
        vecs[6] = '{16'h7FFF, 1'b1, 8'h7F, 1'b1};
        vecs[7] = '{16'hFF7F, 1'b0, 8'h7F, 1'b1};
        vecs[8] = '{16'hFF7F, 1'b1, 8'h80, 1'b1};
        vecs[9] = '{16'h0000, 1'b1, 8'h00, 1'b0};

        q.delete();
        m_cnt  = 0;
        m_cnt2 = 0;
        m_stk  = 0;
        rst_n  = 1'b0;
        drive(1'b1, 16'h0080, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        chk("in_ready_held_in_reset", in_ready, 0);
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        tick();
        chk("in_ready_after_release", in_ready, 1);

        // Back-to-back table vectors with out_ready high: one result per cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].din, vecs[i].sat, 1'b1, 1'b0);
            tick();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_dat);
            chk($sformatf("vec%0d_ovf", i), out_overflow, vecs[i].exp_ovf);
            if (i == 3) chk("count_after_sat_pair", overflow_count, 2);
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        tick();
        chk("count_after_table", overflow_count, 6);
        chk("count_c2_saturated", c2_count, 3);
        chk("sticky_after_table", overflow_sticky, 1);

        // Clear together with an overflow accept keeps the event.
        drive(1'b1, 16'h0080, 1'b1, 1'b1, 1'b1);
        tick();
        chk("clear_with_event_count", overflow_count, 1);
        chk("clear_with_event_c2", c2_count, 1);
        chk("clear_with_event_sticky", overflow_sticky, 1);
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        tick();
        chk("clear_alone", {overflow_sticky, overflow_count}, 0);
        chk("clear_alone_c2", {c2_sticky, c2_count}, 0);

        // Backpressure: third sample must wait for the skid to drain.
        drive(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp_in_ready_low", in_ready, 0);
        drive(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
        tick();
        chk("bp_held_data", out_data, 8'h01);
        chk("bp_in_ready_still_low", in_ready, 0);
        drive(1'b1, 16'h0003, 1'b1, 1'b1, 1'b0);
        tick();
        chk("bp_second_out", out_data, 8'h02);
        tick();
        chk("bp_third_out", out_data, 8'h03);
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        tick();
        chk("bp_drained", out_valid, 0);

        // Reset with the output held and the skid full.
        drive(1'b1, 16'h0005, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0200, 1'b1, 1'b0, 1'b0);
        tick();
        chk("pre_reset_skid_full", in_ready, 0);
        chk("pre_reset_count", overflow_count, 1);
        rst_n = 1'b0;
        tick();
        chk("mid_reset_out_valid", out_valid, 0);
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        tick();
        chk("post_reset_in_ready", in_ready, 1);
        drive(1'b1, 16'h0042, 1'b1, 1'b1, 1'b0);
        tick();
        chk("post_reset_first_data", {out_valid, out_overflow, out_data}, {1'b1, 1'b0, 8'h42});

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] d;
            if ($urandom_range(0, 1) == 0) d = 16'($urandom);
            else                           d = 16'(int'($urandom_range(0, 600)) - 300);
            rst_n = ($urandom_range(0, 399) != 0);
            drive($urandom_range(0, 9) < 7, d, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            tick();
        end
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 4; n++) tick();
        chk("final_drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
